// File: rtl/array_unsigned_mult8_reg.sv
// rtl/array_unsigned_mult8_reg.sv - 8x8 unsigned ripple array multiplier with registered 16-bit product
//
// Purpose:
//   Fixed-width unsigned multiply leaf. AND-gate partial products are summed
//   row by row through 8-bit ripple adder rows. The product register is the
//   only state, so the latency is exactly one clock and every edge captures
//   a new result.
//
// Ports (array_unsigned_mult8_reg):
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous active-high reset, clears product
//   A        in   8   unsigned multiplicand
//   B        in   8   unsigned multiplier
//   product  out  16  registered A*B
//
// Helper modules in this file:
//   array_mult_ha   half adder cell
//   array_mult_fa   full adder cell
//   array_mult_row  one 8-bit adder row (half adder at LSB, full adders above)

module array_mult_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module array_mult_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// One array row: adds this row's partial products to the previous row's
// result shifted down by one bit (prev already carries the previous row's
// carry-out in its MSB). The carries ripple through distinct nets so each
// bit is a separate combinational node.
module array_mult_row (
  input  logic [7:0] pp,
  input  logic [7:0] prev,
  output logic [7:0] sum,
  output logic       cout
);
  logic c1, c2, c3, c4, c5, c6, c7;
  logic s0, s1, s2, s3, s4, s5, s6, s7;

  array_mult_ha u_b0 (.a(pp[0]), .b(prev[0]),          .s(s0), .c(c1));
  array_mult_fa u_b1 (.a(pp[1]), .b(prev[1]), .ci(c1), .s(s1), .co(c2));
  array_mult_fa u_b2 (.a(pp[2]), .b(prev[2]), .ci(c2), .s(s2), .co(c3));
  array_mult_fa u_b3 (.a(pp[3]), .b(prev[3]), .ci(c3), .s(s3), .co(c4));
  array_mult_fa u_b4 (.a(pp[4]), .b(prev[4]), .ci(c4), .s(s4), .co(c5));
  array_mult_fa u_b5 (.a(pp[5]), .b(prev[5]), .ci(c5), .s(s5), .co(c6));
  array_mult_fa u_b6 (.a(pp[6]), .b(prev[6]), .ci(c6), .s(s6), .co(c7));
  array_mult_fa u_b7 (.a(pp[7]), .b(prev[7]), .ci(c7), .s(s7), .co(cout));

  assign sum = {s7, s6, s5, s4, s3, s2, s1, s0};
endmodule

module array_unsigned_mult8_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] product
);
  // Partial-product rows: row k is A gated by B[k].
  logic [7:0] pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7;

  assign pp0 = A & {8{B[0]}};
  assign pp1 = A & {8{B[1]}};
  assign pp2 = A & {8{B[2]}};
  assign pp3 = A & {8{B[3]}};
  assign pp4 = A & {8{B[4]}};
  assign pp5 = A & {8{B[5]}};
  assign pp6 = A & {8{B[6]}};
  assign pp7 = A & {8{B[7]}};

  // Row results. Row 0 is the raw partial-product row with no carry-out.
  logic [7:0] sum0, sum1, sum2, sum3, sum4, sum5, sum6, sum7;
  logic       cout0, cout1, cout2, cout3, cout4, cout5, cout6, cout7;

  assign sum0  = pp0;
  assign cout0 = 1'b0;

  // Each row consumes the previous row's upper 7 sum bits plus its carry-out;
  // the previous row's LSB has reached its final weight and drops out as a
  // product bit.
  array_mult_row u_row1 (.pp(pp1), .prev({cout0, sum0[7:1]}), .sum(sum1), .cout(cout1));
  array_mult_row u_row2 (.pp(pp2), .prev({cout1, sum1[7:1]}), .sum(sum2), .cout(cout2));
  array_mult_row u_row3 (.pp(pp3), .prev({cout2, sum2[7:1]}), .sum(sum3), .cout(cout3));
  array_mult_row u_row4 (.pp(pp4), .prev({cout3, sum3[7:1]}), .sum(sum4), .cout(cout4));
  array_mult_row u_row5 (.pp(pp5), .prev({cout4, sum4[7:1]}), .sum(sum5), .cout(cout5));
  array_mult_row u_row6 (.pp(pp6), .prev({cout5, sum5[7:1]}), .sum(sum6), .cout(cout6));
  array_mult_row u_row7 (.pp(pp7), .prev({cout6, sum6[7:1]}), .sum(sum7), .cout(cout7));

  // Low 7 product bits come from each row's LSB; the last row supplies bits
  // 14:7 and its carry-out is bit 15.
  logic [15:0] product_next;

  assign product_next = {cout7, sum7,
                         sum6[0], sum5[0], sum4[0], sum3[0],
                         sum2[0], sum1[0], sum0[0]};

  // Reset wins over the freshly computed result.
  always_ff @(posedge clk) begin
    if (reset) begin
      product <= 16'd0;
    end else begin
      product <= product_next;
    end
  end

endmodule

// File: tb/tb_array_unsigned_mult8_reg.sv
// tb/tb_array_unsigned_mult8_reg.sv - self-checking bench for array_unsigned_mult8_reg

module tb_array_unsigned_mult8_reg;

  logic        clk;
  logic        reset;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] product;

  int n_vec;
  int n_bad;

  array_unsigned_mult8_reg dut (
    .clk     (clk),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%04h) expected %0d (0x%04h)", tag, got, got, exp, exp);
    end
  endtask

  // Present operands on the falling edge, let one rising edge capture them,
  // then compare a moment later against plain integer arithmetic.
  task automatic step(input string tag, input int a, input int b, input bit rst);
    int exp;
    @(negedge clk);
    A     = 8'(a);
    B     = 8'(b);
    reset = rst;
    @(posedge clk);
    #1;
    exp = rst ? 0 : (a * b);
    check(tag, product, 16'(exp));
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    A     = 8'h00;
    B     = 8'h00;
    reset = 1'b1;

    // Reset held for three edges with maximum operands.
    for (int k = 0; k < 3; k++) step("reset_hold", 255, 255, 1'b1);
    step("reset_release", 255, 255, 1'b0);

    // Output holds while operands stay constant.
    @(negedge clk);
    check("hold_mid", product, 16'd65025);
    step("hold_edge", 255, 255, 1'b0);

    // Identity and zero.
    step("one_x_zero", 1, 0, 1'b0);
    step("one_x_200", 1, 200, 1'b0);
    step("zero_x_255", 0, 255, 1'b0);
    step("255_x_one", 255, 1, 1'b0);

    // Small values and commutativity.
    step("10x3", 10, 3, 1'b0);
    step("3x10", 3, 10, 1'b0);

    // Large and maximum.
    step("208x160", 208, 160, 1'b0);
    step("max", 255, 255, 1'b0);

    // Back-to-back stream, then with a one-edge reset in the middle.
    step("stream0", 10, 3, 1'b0);
    step("stream1", 208, 160, 1'b0);
    step("stream2", 255, 255, 1'b0);
    step("mid_pre", 10, 3, 1'b0);
    step("mid_reset", 208, 160, 1'b1);
    step("mid_post", 255, 255, 1'b0);

    // Random operands with occasional reset pulses.
    for (int k = 0; k < 1000; k++) begin
      int a, b;
      bit r;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      r = ($urandom_range(0, 31) == 0);
      step("random", a, b, r);
    end

    // Exhaustive sweep of every operand pair.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        step("sweep", a, b, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
